vga_driver: RTL and testbench

Display stage downstream of the ping-pong edge-map buffer. It generates 640x480@60 VGA timing at one pixel per clock and reads the buffered 320x200 binary edge image from the buffer's read port. It maps each bit to an RGB565 colour centred on screen and runs the read-side buffer handshake: the frame-done pulse and the ping-pong select.

---
 rtl/vga_pkg.sv | 44 ++++
 rtl/vga_timing_gen.sv | 49 ++++
 rtl/vga_driver.sv | 125 ++++++++++++
 tb/tb_vga_driver.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants, edge-map window geometry and pipeline flag type
//
// Purpose: shared constants for vga_timing_gen and vga_driver.
// Ports:   none (package).
package vga_pkg;

    // Horizontal timing, in pixel clocks
    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_FP         = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BP         = 10'd48;
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;

    // Vertical timing, in lines
    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_FP         = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BP         = 10'd33;
    localparam logic [9:0] V_TOTAL      = 10'd525;
    localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    // Centred 320x200 edge-map window
    localparam logic [9:0]  WIN_X0     = 10'd160;
    localparam logic [9:0]  WIN_Y0     = 10'd140;
    localparam logic [9:0]  WIN_W      = 10'd320;
    localparam logic [9:0]  WIN_H      = 10'd200;
    localparam logic [9:0]  WIN_X1     = WIN_X0 + WIN_W;
    localparam logic [9:0]  WIN_Y1     = WIN_Y0 + WIN_H;
    localparam logic [15:0] WIN_PIXELS = 16'd64000;

    // Per-pixel attributes carried alongside the buffer read latency
    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic active;
        logic in_win;
    } vga_flags_t;

    localparam vga_flags_t FLAGS_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, active: 1'b0, in_win: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 800x525 raster counters with sync and active decode
//
// Purpose: free-running pixel/line counters; sync and active are combinational
//          decodes of the current counter values.
// Ports:   clk, rst_n        pixel clock, async active-low reset
//          hcnt, vcnt        current pixel column 0..799 / line 0..524
//          hsync_n, vsync_n  active-low syncs for the current counter values
//          active            1 inside the 640x480 visible area
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       active
);

    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_TOTAL - 10'd1) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_TOTAL - 10'd1) ? '0 : vcnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt    = hcnt_q;
    assign vcnt    = vcnt_q;
    assign hsync_n = !((hcnt_q >= H_SYNC_START) && (hcnt_q < H_SYNC_END));
    assign vsync_n = !((vcnt_q >= V_SYNC_START) && (vcnt_q < V_SYNC_END));
    assign active  = (hcnt_q < H_ACTIVE) && (vcnt_q < V_ACTIVE);

endmodule

// File: rtl/vga_driver.sv
// rtl/vga_driver.sv - VGA display of the 320x200 edge map with ping-pong read handshake
//
// Purpose: reads the edge buffer inside the centred window, colours each bit
//          and drives VGA; pulses rd_end at the first blanking line and swaps
//          the ping-pong select when the writer has a finished frame.
// Ports:   clk, rst_n                pixel clock, async active-low reset
//          din                       buffer read data, one cycle after rd_en
//          wr_end                    writer has a complete frame pending
//          rd_addr, rd_en            buffer read port
//          rd_end                    one-cycle end-of-displayed-frame pulse
//          rd_addr_sel               0 = display RAM1, 1 = display RAM0
//          vga_hsync, vga_vsync      active-low syncs, aligned with vga_rgb
//          vga_rgb                   RGB565 pixel, 0 in blanking
module vga_driver
    import vga_pkg::*;
#(
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        wr_end,
    output logic [15:0] rd_addr,
    output logic        rd_en,
    output logic        rd_end,
    output logic        rd_addr_sel,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [15:0] vga_rgb
);

    logic [9:0] hcnt, vcnt;
    logic       hsync_n, vsync_n, active;

    vga_timing_gen u_timing (
        .clk     (clk),
        .rst_n   (rst_n),
        .hcnt    (hcnt),
        .vcnt    (vcnt),
        .hsync_n (hsync_n),
        .vsync_n (vsync_n),
        .active  (active)
    );

    logic in_win;
    logic frame_bnd;

    assign in_win    = (hcnt >= WIN_X0) && (hcnt < WIN_X1) && (vcnt >= WIN_Y0) && (vcnt < WIN_Y1);
    assign frame_bnd = (hcnt == 10'd0) && (vcnt == V_ACTIVE);

    logic [15:0] addr_cnt_q, addr_cnt_d;
    logic [15:0] rd_addr_q, rd_addr_d;
    logic        rd_en_q, rd_en_d;
    logic        rd_end_q, rd_end_d;
    logic        sel_q, sel_d;
    vga_flags_t  flags1_q, flags1_d;
    vga_flags_t  flags2_q, flags2_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [15:0] rgb_q, rgb_d;

    always_comb begin
        // Raster order inside the window equals linear buffer order, so a
        // running count replaces (y*320 + x).
        addr_cnt_d = addr_cnt_q;
        if (frame_bnd) begin
            addr_cnt_d = '0;
        end else if (in_win) begin
            addr_cnt_d = addr_cnt_q + 16'd1;
        end

        rd_en_d   = in_win;
        rd_addr_d = in_win ? addr_cnt_q : 16'd0;

        rd_end_d = frame_bnd;
        sel_d    = (frame_bnd && wr_end) ? !sel_q : sel_q;

        flags1_d = '{hsync_n: hsync_n, vsync_n: vsync_n, active: active, in_win: in_win};
        flags2_d = flags1_q;

        // flags2 lines up with din: both describe the same counter cycle
        hsync_d = flags2_q.hsync_n;
        vsync_d = flags2_q.vsync_n;
        rgb_d   = 16'h0000;
        if (flags2_q.active) begin
            rgb_d = (flags2_q.in_win && din) ? FG_COLOR : BG_COLOR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt_q <= '0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            rd_end_q   <= 1'b0;
            sel_q      <= 1'b0;
            flags1_q   <= FLAGS_IDLE;
            flags2_q   <= FLAGS_IDLE;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            rgb_q      <= '0;
        end else begin
            addr_cnt_q <= addr_cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_en_q    <= rd_en_d;
            rd_end_q   <= rd_end_d;
            sel_q      <= sel_d;
            flags1_q   <= flags1_d;
            flags2_q   <= flags2_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            rgb_q      <= rgb_d;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign rd_en       = rd_en_q;
    assign rd_end      = rd_end_q;
    assign rd_addr_sel = sel_q;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_rgb     = rgb_q;

endmodule

// File: tb/tb_vga_driver.sv
// tb/tb_vga_driver.sv - self-checking bench for vga_driver against a raster-arithmetic model
module tb_vga_driver;

    localparam logic [15:0] FG = 16'hF81F;
    localparam logic [15:0] BG = 16'h07E0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        wr_end = 1'b0;
    logic [15:0] rd_addr;
    logic        rd_en;
    logic        rd_end;
    logic        rd_addr_sel;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [15:0] vga_rgb;

    vga_driver #(.FG_COLOR(FG), .BG_COLOR(BG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .wr_end      (wr_end),
        .rd_addr     (rd_addr),
        .rd_en       (rd_en),
        .rd_end      (rd_end),
        .rd_addr_sel (rd_addr_sel),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_rgb     (vga_rgb)
    );

    always #20 clk = ~clk;

    // Edge-map buffer read port: one-cycle registered read
    bit mem [0:63999];
    always @(posedge clk) if (rd_en) din <= mem[rd_addr];

    int n_vec = 0;
    int n_err = 0;
    int cur_k = 0;
    int first_rd = -1;
    int n_rdend = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s k=%0d got=%0h want=%0h", tag, cur_k, got, want);
        end
    endtask

    // Raster position of counter cycle i (i = clocks since reset release)
    function automatic int f_h(input int i); return i % 800; endfunction
    function automatic int f_v(input int i); return (i / 800) % 525; endfunction
    function automatic bit f_win(input int i);
        return f_h(i) >= 160 && f_h(i) < 480 && f_v(i) >= 140 && f_v(i) < 340;
    endfunction
    function automatic bit f_act(input int i); return f_h(i) < 640 && f_v(i) < 480; endfunction
    function automatic bit f_bnd(input int i); return f_h(i) == 0 && f_v(i) == 480; endfunction
    function automatic int f_addr(input int i); return (f_v(i) - 140) * 320 + (f_h(i) - 160); endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_rd"}, {rd_en, rd_addr, rd_end, rd_addr_sel}, 19'h0);
        chk({tag, "_vga"}, {vga_hsync, vga_vsync, vga_rgb}, {1'b1, 1'b1, 16'h0});
    endtask

    // Checks every cycle from release (k=0) to k_end; sched drives the wr_end scenario
    task automatic run(input int k_end, input bit sched);
        int          nrd;
        bit          sel_m;
        bit          wr_prev;
        bit          b;
        int          i;
        logic [15:0] a16;
        logic [15:0] rgb_e;
        logic        hs_e, vs_e;
        nrd = 0;
        sel_m = 1'b0;
        wr_prev = 1'b0;
        for (int k = 0; k <= k_end; k++) begin
            if (k > 0) @(negedge clk);
            cur_k = k;

            b = (k >= 1) && f_bnd(k - 1);
            if (b && wr_prev) sel_m = ~sel_m;
            a16 = '0;
            if (k >= 1 && f_win(k - 1)) a16 = 16'(f_addr(k - 1));
            chk("rd_port", {rd_en, rd_addr, rd_end, rd_addr_sel},
                {(k >= 1 && f_win(k - 1)), a16, b, sel_m});

            hs_e = 1'b1;
            vs_e = 1'b1;
            rgb_e = 16'h0;
            if (k >= 3) begin
                i = k - 3;
                hs_e = !(f_h(i) >= 656 && f_h(i) < 752);
                vs_e = !(f_v(i) >= 490 && f_v(i) < 492);
                if (f_act(i)) rgb_e = (f_win(i) && mem[f_addr(i)]) ? FG : BG;
            end
            chk("vga_out", {vga_hsync, vga_vsync, vga_rgb}, {hs_e, vs_e, rgb_e});

            if (rd_en) begin
                nrd++;
                if (first_rd < 0) first_rd = k;
            end
            if (rd_end) n_rdend++;
            if (b) begin
                chk("frame_rd_cnt", nrd, 64000);
                nrd = 0;
            end

            // Writer: full frame ready at start, next one lands mid-frame at
            // vcnt 200 of frame 1, none for frame 2.
            if (sched && (k == 0 || k == 420000 + 200 * 800)) wr_end = 1'b1;
            if (rd_end && wr_end) wr_end = 1'b0;
            wr_prev = wr_end;
            if (n_err >= 40) return;
        end
    endtask

    initial begin
        for (int j = 0; j < 64000; j++) mem[j] = bit'($urandom_range(0, 1));
        mem[0] = 1'b1;
        mem[63999] = 1'b1;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;
        run(250 * 800 + 37, 1'b0);

        if (n_err < 40) begin
            rst_n = 1'b0;
            #1;
            chk_reset("async_rst");
            repeat (5) @(posedge clk);
            @(negedge clk);
            chk_reset("held_rst");
            rst_n = 1'b1;
            first_rd = -1;
            n_rdend = 0;
            run(1224005, 1'b1);
            if (n_err < 40) begin
                chk("first_rd_k", first_rd, 140 * 800 + 160 + 1);
                chk("rd_end_pulses", n_rdend, 3);
                chk("sel_final", rd_addr_sel, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
